// File: rtl/risc_pkg.sv
// Shared widths, opcode encodings and bus select encodings for the
// four-register processor datapath and its control unit.
package risc_pkg;

  localparam int word_size = 8;
  localparam int op_size   = 4;
  localparam int sel1_size = 3;
  localparam int sel2_size = 2;

  typedef logic [word_size-1:0] word_t;

  typedef enum logic [op_size-1:0] {
    op_nop = 4'd0,
    op_add = 4'd1,
    op_sub = 4'd2,
    op_and = 4'd3,
    op_not = 4'd4,
    op_rd  = 4'd5,
    op_wr  = 4'd6,
    op_br  = 4'd7,
    op_brz = 4'd8
  } opcode_e;

  typedef enum logic [sel1_size-1:0] {
    sel1_r0 = 3'd0,
    sel1_r1 = 3'd1,
    sel1_r2 = 3'd2,
    sel1_r3 = 3'd3,
    sel1_pc = 3'd4
  } sel1_e;

  typedef enum logic [sel2_size-1:0] {
    sel2_alu  = 2'd0,
    sel2_bus1 = 2'd1,
    sel2_mem  = 2'd2
  } sel2_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: A is the Y operand register, B is bus_1.
// Arithmetic wraps modulo 2^8; opcodes without an ALU action yield zero.
module alu_unit
  import risc_pkg::*;
(
  input  logic [op_size-1:0]   opcode_i,
  input  logic [word_size-1:0] a_i,
  input  logic [word_size-1:0] b_i,
  output logic [word_size-1:0] result_o,
  output logic                 zero_o
);

  always_comb begin
    result_o = '0;
    case (opcode_e'(opcode_i))
      op_add:  result_o = a_i + b_i;
      op_sub:  result_o = a_i - b_i;
      op_and:  result_o = a_i & b_i;
      op_not:  result_o = ~b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/processing_unit.sv
// Datapath of the four-register processor: register file, PC, IR, address
// register, ALU operand Y, zero flag Z, and the two bus multiplexers.
module processing_unit
  import risc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_r0,
  input  logic                 load_r1,
  input  logic                 load_r2,
  input  logic                 load_r3,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 load_ir,
  input  logic                 load_add_r,
  input  logic                 load_reg_y,
  input  logic                 load_reg_z,
  input  logic [sel1_size-1:0] sel_bus_1_mux,
  input  logic [sel2_size-1:0] sel_bus_2_mux,
  input  logic [word_size-1:0] mem_word,
  output logic [word_size-1:0] instruction,
  output logic                 zero,
  output logic [word_size-1:0] address,
  output logic [word_size-1:0] bus_1
);

  word_t r0_q, r1_q, r2_q, r3_q, pc_q, ir_q, add_r_q, y_q;
  word_t r0_d, r1_d, r2_d, r3_d, pc_d, ir_d, add_r_d, y_d;
  logic  z_q, z_d;

  word_t bus_1_mux, bus_2_mux, alu_out;
  logic  alu_zero;

  alu_unit u_alu (
    .opcode_i (ir_q[word_size-1:word_size-op_size]),
    .a_i      (y_q),
    .b_i      (bus_1_mux),
    .result_o (alu_out),
    .zero_o   (alu_zero)
  );

  // Unused select codes drive zero so the buses never carry X.
  always_comb begin
    bus_1_mux = '0;
    case (sel1_e'(sel_bus_1_mux))
      sel1_r0: bus_1_mux = r0_q;
      sel1_r1: bus_1_mux = r1_q;
      sel1_r2: bus_1_mux = r2_q;
      sel1_r3: bus_1_mux = r3_q;
      sel1_pc: bus_1_mux = pc_q;
      default: bus_1_mux = '0;
    endcase
  end

  always_comb begin
    bus_2_mux = '0;
    case (sel2_e'(sel_bus_2_mux))
      sel2_alu:  bus_2_mux = alu_out;
      sel2_bus1: bus_2_mux = bus_1_mux;
      sel2_mem:  bus_2_mux = mem_word;
      default:   bus_2_mux = '0;
    endcase
  end

  always_comb begin
    r0_d    = load_r0    ? bus_2_mux : r0_q;
    r1_d    = load_r1    ? bus_2_mux : r1_q;
    r2_d    = load_r2    ? bus_2_mux : r2_q;
    r3_d    = load_r3    ? bus_2_mux : r3_q;
    ir_d    = load_ir    ? bus_2_mux : ir_q;
    add_r_d = load_add_r ? bus_2_mux : add_r_q;
    y_d     = load_reg_y ? bus_2_mux : y_q;
    z_d     = load_reg_z ? alu_zero  : z_q;
    // A jump load wins over the fetch increment.
    pc_d    = pc_q;
    if (load_pc) begin
      pc_d = bus_2_mux;
    end else if (inc_pc) begin
      pc_d = pc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      add_r_q <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      add_r_q <= add_r_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign instruction = ir_q;
  assign zero        = z_q;
  assign address     = add_r_q;
  assign bus_1       = bus_1_mux;

endmodule

// File: tb/tb_processing_unit.sv
// Directed bench for processing_unit: reset, fetch, PC priority/wrap,
// ALU operations and out-of-range bus selects, with hand-computed results.
module tb_processing_unit;

  logic       clk, rst;
  logic       load_r0, load_r1, load_r2, load_r3;
  logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
  logic [2:0] sel_bus_1_mux;
  logic [1:0] sel_bus_2_mux;
  logic [7:0] mem_word;
  logic [7:0] instruction, address, bus_1;
  logic       zero;
  logic [7:0] rd;

  int n_checks = 0;
  int n_fail   = 0;

  processing_unit dut (
    .clk           (clk),
    .rst           (rst),
    .load_r0       (load_r0),
    .load_r1       (load_r1),
    .load_r2       (load_r2),
    .load_r3       (load_r3),
    .load_pc       (load_pc),
    .inc_pc        (inc_pc),
    .load_ir       (load_ir),
    .load_add_r    (load_add_r),
    .load_reg_y    (load_reg_y),
    .load_reg_z    (load_reg_z),
    .sel_bus_1_mux (sel_bus_1_mux),
    .sel_bus_2_mux (sel_bus_2_mux),
    .mem_word      (mem_word),
    .instruction   (instruction),
    .zero          (zero),
    .address       (address),
    .bus_1         (bus_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    load_r0 = 0; load_r1 = 0; load_r2 = 0; load_r3 = 0;
    load_pc = 0; inc_pc = 0; load_ir = 0; load_add_r = 0;
    load_reg_y = 0; load_reg_z = 0;
  endtask

  // Inputs change 1 ns after the rising edge and are sampled before the next.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic read_bus1(input logic [2:0] s, output logic [7:0] v);
    sel_bus_1_mux = s;
    #1;
    v = bus_1;
  endtask

  // dst: 0-3 = R0-R3, 4 = PC, 5 = IR, 6 = address reg, 7 = Y
  task automatic mem_load(input logic [7:0] v, input int dst);
    mem_word      = v;
    sel_bus_2_mux = 2'd2;
    case (dst)
      0: load_r0    = 1;
      1: load_r1    = 1;
      2: load_r2    = 1;
      3: load_r3    = 1;
      4: load_pc    = 1;
      5: load_ir    = 1;
      6: load_add_r = 1;
      default: load_reg_y = 1;
    endcase
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_strobes();
    mem_word = 8'h00; sel_bus_1_mux = 3'd0; sel_bus_2_mux = 2'd0;
    #12;
    check("rst_instruction", instruction, 8'h00);
    check("rst_zero", {7'b0, zero}, 8'h00);
    check("rst_address", address, 8'h00);
    check("rst_bus_1", bus_1, 8'h00);
    @(negedge clk) rst = 1'b1;
    tick();

    // One bus_2 value captured by every enabled register at once
    mem_word = 8'hA5; sel_bus_2_mux = 2'd2;
    load_r0 = 1; load_r1 = 1; load_r2 = 1; load_r3 = 1; load_pc = 1;
    load_ir = 1; load_add_r = 1; load_reg_y = 1; load_reg_z = 1;
    tick();
    check("multi_instruction", instruction, 8'hA5);
    check("multi_address", address, 8'hA5);
    check("multi_zero", {7'b0, zero}, 8'h01);
    read_bus1(3'd0, rd); check("multi_r0", rd, 8'hA5);
    read_bus1(3'd3, rd); check("multi_r3", rd, 8'hA5);
    read_bus1(3'd4, rd); check("multi_pc", rd, 8'hA5);

    // Mid-cycle asynchronous reset, then loads attempted while held
    tick();
    sel_bus_1_mux = 3'd4;
    #3 rst = 1'b0;
    #1;
    check("arst_instruction", instruction, 8'h00);
    check("arst_zero", {7'b0, zero}, 8'h00);
    check("arst_address", address, 8'h00);
    check("arst_pc", bus_1, 8'h00);
    mem_word = 8'h77; sel_bus_2_mux = 2'd2;
    load_r0 = 1; load_pc = 1; load_ir = 1; load_add_r = 1; load_reg_z = 1;
    tick();
    check("hold_instruction", instruction, 8'h00);
    check("hold_address", address, 8'h00);
    read_bus1(3'd4, rd); check("hold_pc", rd, 8'h00);
    read_bus1(3'd0, rd); check("hold_r0", rd, 8'h00);
    rst = 1'b1;
    tick();

    // Fetch
    mem_load(8'h03, 4);
    sel_bus_1_mux = 3'd4; sel_bus_2_mux = 2'd1; load_add_r = 1;
    tick();
    check("fetch_address", address, 8'h03);
    mem_word = 8'h16; sel_bus_2_mux = 2'd2; load_ir = 1; inc_pc = 1;
    tick();
    check("fetch_instruction", instruction, 8'h16);
    read_bus1(3'd4, rd); check("fetch_pc", rd, 8'h04);

    // PC wrap and load priority
    mem_load(8'hFF, 4);
    inc_pc = 1;
    tick();
    read_bus1(3'd4, rd); check("pc_wrap", rd, 8'h00);
    mem_word = 8'h40; sel_bus_2_mux = 2'd2; load_pc = 1; inc_pc = 1;
    tick();
    read_bus1(3'd4, rd); check("pc_priority", rd, 8'h40);

    // SUB: 0x05 - 0x05 = 0x00, zero set
    mem_load(8'h20, 5);
    mem_load(8'h05, 7);
    mem_load(8'h05, 1);
    sel_bus_1_mux = 3'd1; sel_bus_2_mux = 2'd0; load_r1 = 1; load_reg_z = 1;
    tick();
    read_bus1(3'd1, rd); check("sub_r1", rd, 8'h00);
    check("sub_zero", {7'b0, zero}, 8'h01);

    // ADD: 0xF0 + 0x20 wraps to 0x10, zero cleared
    mem_load(8'h10, 5);
    mem_load(8'hF0, 7);
    mem_load(8'h20, 2);
    check("z_holds", {7'b0, zero}, 8'h01);
    sel_bus_1_mux = 3'd2; sel_bus_2_mux = 2'd0; load_r2 = 1; load_reg_z = 1;
    tick();
    read_bus1(3'd2, rd); check("add_r2", rd, 8'h10);
    check("add_zero", {7'b0, zero}, 8'h00);

    // NOT: ~0x0F = 0xF0 into R0
    mem_load(8'h40, 5);
    mem_load(8'h0F, 3);
    sel_bus_1_mux = 3'd3; sel_bus_2_mux = 2'd0; load_r0 = 1;
    tick();
    read_bus1(3'd0, rd); check("not_r0", rd, 8'hF0);
    check("not_zero_held", {7'b0, zero}, 8'h00);

    // Out-of-range bus_1 selects
    read_bus1(3'd5, rd); check("sel1_5", rd, 8'h00);
    read_bus1(3'd6, rd); check("sel1_6", rd, 8'h00);
    read_bus1(3'd7, rd); check("sel1_7", rd, 8'h00);

    // Out-of-range bus_2 select: R0 (0xF0) overwritten with 0x00
    sel_bus_1_mux = 3'd3; sel_bus_2_mux = 2'd3; load_r0 = 1;
    tick();
    read_bus1(3'd0, rd); check("sel2_3_r0", rd, 8'h00);

    // AND: Y = 0xF0 & R0 = 0xAA -> 0xA0 into R2
    mem_load(8'hAA, 0);
    mem_load(8'h30, 5);
    sel_bus_1_mux = 3'd0; sel_bus_2_mux = 2'd0; load_r2 = 1;
    tick();
    read_bus1(3'd2, rd); check("and_r2", rd, 8'hA0);

    // Opcode 5 has no ALU action: R3 (0x0F) becomes 0x00
    mem_load(8'h50, 5);
    sel_bus_1_mux = 3'd0; sel_bus_2_mux = 2'd0; load_r3 = 1;
    tick();
    read_bus1(3'd3, rd); check("nop_alu_r3", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
